fmul_pipe: RTL
==============

Name: fmul_pipe

Overview:
- Pipelined IEEE-754 binary32 multiplier; the inverse operation to the FPU divider. Feeds the same FPU result mux, and divide results can be checked by multiplying back.
- Three-stage pipeline with valid/ready handshakes on both sides, a passthrough tag for result routing, and a full-pipeline stall on back-pressure.
- Rounding is round-to-nearest-even. Subnormals are flushed to zero on input and output.

Parameters:
TAG_W, 4, width of the opaque tag carried alongside each operation
CANON_NAN, 32'h7fc00000, value emitted for any NaN result

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands a, b and in_tag are valid
in_ready  out  1  pipeline accepts an operation this cycle
a  in  32  binary32 multiplicand
b  in  32  binary32 multiplier
in_tag  in  TAG_W  tag returned with the result
out_valid  out  1  q and out_tag are valid
out_ready  in  1  consumer accepts the result this cycle
q  out  32  binary32 product
out_tag  out  TAG_W  tag of the operation producing q

Behaviour:
- Reset: all stage valid bits clear; out_valid=0; q=0; out_tag=0; in_ready=1 in the cycle after rst is sampled high.
- Reset mid-operation: all in-flight operations are discarded; no result from before reset ever appears.
- Handshake: an input transfers when in_valid && in_ready. An output transfers when out_valid && out_ready. Once out_valid=1, q and out_tag hold stable until out_ready=1.
- Stall: global advance enable adv = !out_valid || out_ready; in_ready = adv. When adv=0 every stage register holds. Bubbles are not compressed.
- Latency: 3 cycles from input transfer to out_valid, with no stall. Throughput is 1 operation per cycle.
- Stage 1, unpack:
  - Split sign, exponent and mantissa; insert the hidden 1.
  - Classify each operand as zero (exponent 0, any mantissa, i.e. subnormals flushed), inf, NaN, or normal.
  - Result sign = sa ^ sb.
  - Special result codes:
    - any NaN -> CANON_NAN (sign not applied)
    - 0 * inf -> CANON_NAN
    - inf * x -> signed inf
    - 0 * x -> signed zero
- Stage 2, multiply: 24x24 -> 48-bit unsigned product. Biased exponent sum ea+eb-127, held as 10-bit signed.
- Stage 3, normalize and round:
  - If product bit 47 is set, shift right 1 and increment the exponent.
  - Guard, round and sticky bits taken from the discarded bits; round to nearest even.
  - Rounding carry-out renormalizes and increments the exponent.
- Exponent rules:
  - final exponent >= 255 -> signed inf (0x7f800000 / 0xff800000)
  - final exponent <= 0 -> signed zero (flush to zero, no subnormal output)
- Special codes from stage 1 bypass the arithmetic result in stage 3.
- No exception flags are produced.

Decomposition:
- Shared package fpu_pkg holds:
  - field-width constants (EXP_W=8, MAN_W=23, BIAS=127)
  - the class enum {ZERO, NORM, INF, NAN}
  - the canonical NaN and inf constants, reused by the divider
- One sub-module, fp32_unpack: combinational classify/split, instantiated twice in stage 1.

Test Plan:
- Basic products, back-to-back with out_ready=1:
  - 0x40000000 * 0x3f000000 -> 0x3f800000
  - 0x3fc00000 * 0x3fc00000 -> 0x40100000
  - 0x40400000 * 0xc0000000 -> 0xc0c00000
  - each arrives exactly 3 cycles after its input transfer, with tags 1, 2, 3 in order.
- Special operands:
  - 0xffffface * 0x3f800000 -> 0x7fc00000
  - 0x00000000 * 0x7f800000 -> 0x7fc00000
  - 0x80000000 * 0x40000000 -> 0x80000000
  - 0xff800000 * 0x40000000 -> 0xff800000
- Range limits:
  - 0x7f000000 * 0x40000000 -> 0x7f800000 (overflow)
  - 0x00800000 * 0x3f000000 -> 0x00000000 (underflow flush)
  - 0x00400000 (subnormal) * 0x3f800000 -> 0x00000000
- Rounding: 0x3f800001 * 0x3f800001 -> 0x3f800002 (exact 1+2^-22+2^-46, rounds down). 0x3fffffff * 0x3fffffff -> 0x407ffffe (round-to-nearest).
- Back-pressure:
  - Stream 5 ops, then hold out_ready=0 for 4 cycles. out_valid stays 1 and q stays stable; in_ready=0 from the first held cycle.
  - Release out_ready: all 5 results emerge in order, with no loss or duplication.
- Reset mid-stream: with 3 ops in flight, assert rst for 1 cycle. The next cycle has out_valid=0 and q=0, and no stale result appears afterwards; a new op issued afterwards returns after 3 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared binary32 field constants, operand classes and stage records for the FPU datapaths.
package fpu_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   localparam logic [31:0] FP32_CANON_NAN = 32'h7fc00000;
   localparam logic [31:0] FP32_POS_INF   = 32'h7f800000;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_e;

   // Stage 1 record: unpacked operands plus any special-case result
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] ea;
      logic [EXP_W-1:0] eb;
      logic [MAN_W:0]   ma;
      logic [MAN_W:0]   mb;
      logic             spec;
      logic [31:0]      spec_val;
   } mul_s1_t;

   typedef struct packed {
      logic                 sign;
      logic signed [9:0]    exp;
      logic [2*MAN_W+1:0]   prod;
      logic                 spec;
      logic [31:0]          spec_val;
   } mul_s2_t;

   function automatic logic [31:0] fp32_inf(input logic sign);
      return {sign, FP32_POS_INF[30:0]};
   endfunction

   function automatic logic [31:0] fp32_zero(input logic sign);
      return {sign, 31'd0};
   endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Splits a binary32 operand into sign/exponent/significand and classifies it;
// subnormals are treated as zero.
import fpu_pkg::*;

module fp32_unpack (
   input  logic [31:0]      x,
   output logic             sign,
   output logic [EXP_W-1:0] exp,
   output logic [MAN_W:0]   man,
   output fp_class_e        cls
);

   // Field split and class decode
   always_comb begin
      sign = x[31];
      exp  = x[30:23];
      man  = {1'b1, x[22:0]};
      cls  = NORM;
      if (x[30:23] == 8'd0) begin
         cls = ZERO;
      end else if (x[30:23] == 8'hff) begin
         if (x[22:0] == 23'd0) begin
            cls = INF;
         end else begin
            cls = NAN;
         end
      end else begin
         cls = NORM;
      end
   end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage binary32 multiplier (unpack, multiply, normalize/round) with
// valid/ready handshakes, tag passthrough and whole-pipe stall on back-pressure.
import fpu_pkg::*;

module fmul_pipe #(
   parameter int          TAG_W     = 4,
   parameter logic [31:0] CANON_NAN = 32'h7fc00000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      q,
   output logic [TAG_W-1:0] out_tag
);

   logic             ua_sign, ub_sign;
   logic [EXP_W-1:0] ua_exp, ub_exp;
   logic [MAN_W:0]   ua_man, ub_man;
   fp_class_e        ua_cls, ub_cls;

   mul_s1_t          s1_d, s1_q;
   mul_s2_t          s2_d, s2_q;
   logic             v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
   logic [TAG_W-1:0] tag1_d, tag1_q, tag2_d, tag2_q, out_tag_d, out_tag_q;
   logic [31:0]      q_d, q_q;

   logic              adv;
   logic signed [9:0] exp_in, exp_norm, exp_final;
   logic [MAN_W-1:0]  frac_pre;
   logic [MAN_W:0]    frac_rnd;
   logic              guard_bit, round_bit, sticky_bit, round_up;

   fp32_unpack u_unpack_a (.x(a), .sign(ua_sign), .exp(ua_exp), .man(ua_man), .cls(ua_cls));
   fp32_unpack u_unpack_b (.x(b), .sign(ub_sign), .exp(ub_exp), .man(ub_man), .cls(ub_cls));

   // A stalled output freezes every stage; bubbles stay where they are.
   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign q         = q_q;
   assign out_tag   = out_tag_q;

   // Stage 1: operand split and special-result selection
   always_comb begin
      s1_d      = '0;
      v1_d      = in_valid;
      tag1_d    = in_tag;
      s1_d.sign = ua_sign ^ ub_sign;
      s1_d.ea   = ua_exp;
      s1_d.eb   = ub_exp;
      s1_d.ma   = ua_man;
      s1_d.mb   = ub_man;
      if (ua_cls == NAN || ub_cls == NAN ||
          (ua_cls == ZERO && ub_cls == INF) || (ua_cls == INF && ub_cls == ZERO)) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = CANON_NAN;
      end else if (ua_cls == INF || ub_cls == INF) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = fp32_inf(ua_sign ^ ub_sign);
      end else if (ua_cls == ZERO || ub_cls == ZERO) begin
         s1_d.spec     = 1'b1;
         s1_d.spec_val = fp32_zero(ua_sign ^ ub_sign);
      end else begin
         s1_d.spec     = 1'b0;
         s1_d.spec_val = 32'd0;
      end
   end

   // Stage 2: significand product and rebiased exponent sum
   always_comb begin
      v2_d          = v1_q;
      tag2_d        = tag1_q;
      s2_d.sign     = s1_q.sign;
      s2_d.spec     = s1_q.spec;
      s2_d.spec_val = s1_q.spec_val;
      s2_d.prod     = {24'd0, s1_q.ma} * {24'd0, s1_q.mb};
      s2_d.exp      = $signed({2'b00, s1_q.ea}) + $signed({2'b00, s1_q.eb}) - $signed(10'(BIAS));
   end

   // Stage 3: normalize, round to nearest even, range clamp
   always_comb begin
      exp_in = s2_q.exp;
      if (s2_q.prod[47]) begin
         frac_pre   = s2_q.prod[46:24];
         guard_bit  = s2_q.prod[23];
         round_bit  = s2_q.prod[22];
         sticky_bit = |s2_q.prod[21:0];
         exp_norm   = exp_in + 10'sd1;
      end else begin
         frac_pre   = s2_q.prod[45:23];
         guard_bit  = s2_q.prod[22];
         round_bit  = s2_q.prod[21];
         sticky_bit = |s2_q.prod[20:0];
         exp_norm   = exp_in;
      end
      round_up = guard_bit & (round_bit | sticky_bit | frac_pre[0]);
      frac_rnd = {1'b0, frac_pre} + {23'd0, round_up};
      // Carry out of rounding leaves a zero fraction, so only the exponent moves.
      if (frac_rnd[23]) begin
         exp_final = exp_norm + 10'sd1;
      end else begin
         exp_final = exp_norm;
      end
      if (s2_q.spec) begin
         q_d = s2_q.spec_val;
      end else if (exp_final >= 10'sd255) begin
         q_d = fp32_inf(s2_q.sign);
      end else if (exp_final <= 10'sd0) begin
         q_d = fp32_zero(s2_q.sign);
      end else begin
         q_d = {s2_q.sign, exp_final[7:0], frac_rnd[22:0]};
      end
      out_valid_d = v2_q;
      out_tag_d   = tag2_q;
   end

   // Pipeline registers, all advancing together
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         s1_q        <= '0;
         s2_q        <= '0;
         tag1_q      <= '0;
         tag2_q      <= '0;
         out_tag_q   <= '0;
         q_q         <= 32'd0;
      end else if (adv) begin
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         out_valid_q <= out_valid_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
         out_tag_q   <= out_tag_d;
         q_q         <= q_d;
      end
   end

endmodule
